violation_kill_arbiter: RTL and testbench
=========================================

# violation_kill_arbiter

Collects violation requests from several memory-access monitors in the active RoT, picks one per kill event, and drives a single system reset to the MSP430 core. The reset stays asserted for at least a minimum hold time, then stays asserted until the core fetches the reset handler. The block records which monitor caused the kill and keeps a saturating kill count for attestation software. It sits between the per-region monitors and the core's reset input, replacing per-monitor kill state machines with one shared sequencer.

## Interface
- N_SRC, 4: number of violation sources (≥1).
- RESET_HANDLER, 16'hFFFE: PC value that releases the kill.
- HOLD_CYCLES, 8: minimum cycles sys_reset is held before the handler check is enabled (≥1).
- CNT_W, 8: width of kill_count.

- clk  in  1  system clock.
- reset  in  1  synchronous, active-high block reset.
- pc  in  16  current core program counter.
- viol_req  in  N_SRC  level violation request per monitor; bit 0 has highest priority.
- viol_mask  in  N_SRC  per-source enable; masked bits are ignored everywhere.
- cause_clr  in  1  clear request for the sticky cause; honoured only in ARMED.
- sys_reset  out  1  registered kill/reset to the core.
- viol_ack  out  N_SRC  one-cycle one-hot acknowledge to the winning source.
- cause  out  N_SRC  sticky one-hot winner of the most recent kill.
- cause_valid  out  1  cause holds a valid record.
- kill_count  out  CNT_W  saturating number of accepted kills.

## Operation
- Effective request: eff = viol_req & viol_mask. Winner: lowest set index of eff, one-hot.
- State machine states:
  - ARMED: normal operation.
  - HOLD: minimum reset hold.
  - WAIT_HANDLER: waiting for the core to reach RESET_HANDLER.
- ARMED:
  - If eff ≠ 0: go to HOLD and load hold_ctr = HOLD_CYCLES−1.
  - On the same transition: register the winner into cause, set cause_valid = 1, pulse viol_ack on the winner, and increment kill_count (saturating at all-ones).
  - Else if cause_clr = 1: set cause = 0 and cause_valid = 0.
- HOLD:
  - If hold_ctr = 0: go to WAIT_HANDLER.
  - Else: decrement hold_ctr.
  - viol_req and pc are ignored; there is no ack and no count.
- WAIT_HANDLER:
  - If pc == RESET_HANDLER and eff == 0: go to ARMED.
  - Otherwise stay in WAIT_HANDLER. This includes pc at the handler while eff ≠ 0.
  - Requests seen here are not acked, not counted and not latched.
- sys_reset is 1 whenever the next state is HOLD or WAIT_HANDLER, and 0 whenever the next state is ARMED.
- cause_clr is ignored in HOLD and WAIT_HANDLER.
- If a violation and cause_clr arrive in the same ARMED cycle, the violation wins: the new cause is latched and cause_valid = 1.
- cause and kill_count survive kill recovery. Only reset clears them.

## Timing
- Reset values: state ARMED, sys_reset 0, viol_ack 0, cause 0, cause_valid 0, kill_count 0, hold_ctr 0.
- Asserting reset in any state returns to ARMED on the next edge. This includes mid-HOLD and mid-WAIT: sys_reset drops in the following cycle.
- Violation latency: eff sampled high in ARMED at edge t gives the following in cycle t+1:
  - sys_reset = 1, viol_ack pulsed;
  - cause, cause_valid and kill_count updated.
- Hold:
  - HOLD occupies cycles t+1 … t+HOLD_CYCLES.
  - pc is first compared in cycle t+HOLD_CYCLES+1.
  - Earliest sys_reset deassertion is cycle t+HOLD_CYCLES+2.
- Release: pc == RESET_HANDLER and eff == 0 sampled at edge r gives sys_reset = 0 and ARMED from cycle r+1.
- A request already active when the block returns to ARMED starts a new kill on the next edge, and is counted and acked again.
- viol_ack is never high for more than one consecutive cycle per kill event.

## Test plan
- Single kill:
  - Stimulus: HOLD_CYCLES = 8, mask = 4'hF, viol_req = 4'b0100 for one cycle at edge t, pc = 16'hFFFE held throughout.
  - Required: sys_reset high for cycles t+1 … t+9 and low at t+10; viol_ack = 4'b0100 at t+1 only; cause = 4'b0100; kill_count = 1.
- Priority and masking:
  - viol_req = 4'b1010, mask = 4'hF → cause = 4'b0010.
  - Same request with mask = 4'b1101 → cause = 4'b1000.
  - viol_req = 4'b0010, mask = 4'b1101 → no kill.
- Handler gating: pc ≠ 16'hFFFE for 50 cycles after HOLD, then pc = 16'hFFFE with viol_req = 4'b0001 still high.
  - Required: sys_reset stays high through the 50 cycles and while the request is active; it drops one cycle after viol_req falls with pc at the handler; kill_count increments only once.
- Cause clear vs. kill:
  - cause_clr in WAIT_HANDLER → ignored.
  - cause_clr in ARMED → cause = 0, cause_valid = 0.
  - cause_clr in the same cycle as viol_req = 4'b0001 → cause = 4'b0001, cause_valid = 1.
- Saturation: CNT_W = 2, five separate kills → kill_count sequence 1, 2, 3, 3, 3.
- Reset mid-HOLD: assert reset at cycle t+3 of a kill.
  - Required: all outputs at reset values from t+4, state ARMED; a new request is then accepted normally with kill_count = 1.

Source files
------------

// File: rtl/violation_kill_arbiter_if.sv
// Violation/kill bus between the monitors and core side (master) and the kill arbiter (slave).
interface violation_kill_arbiter_if #(
    parameter int unsigned N_SRC = 4,
    parameter int unsigned CNT_W = 8
);
    logic [15:0]      pc;
    logic [N_SRC-1:0] viol_req;
    logic [N_SRC-1:0] viol_mask;
    logic             cause_clr;
    logic             sys_reset;
    logic [N_SRC-1:0] viol_ack;
    logic [N_SRC-1:0] cause;
    logic             cause_valid;
    logic [CNT_W-1:0] kill_count;

    modport master (
        output pc, viol_req, viol_mask, cause_clr,
        input  sys_reset, viol_ack, cause, cause_valid, kill_count
    );

    modport slave (
        input  pc, viol_req, viol_mask, cause_clr,
        output sys_reset, viol_ack, cause, cause_valid, kill_count
    );
endinterface

// File: rtl/violation_kill_arbiter.sv
// Shared kill sequencer: picks one violating monitor, holds the core in reset
// for a minimum time, then until the core fetches the reset handler.
module violation_kill_arbiter #(
    parameter int unsigned N_SRC         = 4,
    parameter logic [15:0] RESET_HANDLER = 16'hFFFE,
    parameter int unsigned HOLD_CYCLES   = 8,
    parameter int unsigned CNT_W         = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    violation_kill_arbiter_if.slave  bus
);
    localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    typedef enum logic [1:0] {
        ARMED,
        HOLD,
        WAIT_HANDLER
    } state_t;

    state_t           state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [N_SRC-1:0] cause_q, cause_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [N_SRC-1:0] ack_q, ack_d;
    logic             sys_reset_q, sys_reset_d;
    logic [N_SRC-1:0] eff;
    logic [N_SRC-1:0] win;

    // Next-state, bookkeeping and output decode
    always_comb begin
        eff         = bus.viol_req & bus.viol_mask;
        win         = eff & (~eff + N_SRC'(1));
        state_d     = state_q;
        hold_d      = hold_q;
        cause_d     = cause_q;
        valid_d     = valid_q;
        count_d     = count_q;
        ack_d       = '0;
        sys_reset_d = 1'b0;

        case (state_q)
            ARMED: begin
                if (|eff) begin
                    state_d = HOLD;
                    hold_d  = HOLD_W'(HOLD_CYCLES - 1);
                    cause_d = win;
                    valid_d = 1'b1;
                    ack_d   = win;
                    if (count_q != '1) begin
                        count_d = count_q + CNT_W'(1);
                    end
                end else if (bus.cause_clr) begin
                    cause_d = '0;
                    valid_d = 1'b0;
                end
            end
            HOLD: begin
                if (hold_q == '0) begin
                    state_d = WAIT_HANDLER;
                end else begin
                    hold_d = hold_q - HOLD_W'(1);
                end
            end
            WAIT_HANDLER: begin
                // A request still pending at the handler keeps the core killed
                if ((bus.pc == RESET_HANDLER) && (eff == '0)) begin
                    state_d = ARMED;
                end
            end
            default: state_d = ARMED;
        endcase

        sys_reset_d = (state_d != ARMED);
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ARMED;
            hold_q      <= '0;
            cause_q     <= '0;
            valid_q     <= 1'b0;
            count_q     <= '0;
            ack_q       <= '0;
            sys_reset_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            cause_q     <= cause_d;
            valid_q     <= valid_d;
            count_q     <= count_d;
            ack_q       <= ack_d;
            sys_reset_q <= sys_reset_d;
        end
    end

    assign bus.sys_reset   = sys_reset_q;
    assign bus.viol_ack    = ack_q;
    assign bus.cause       = cause_q;
    assign bus.cause_valid = valid_q;
    assign bus.kill_count  = count_q;
endmodule

// File: tb/tb_violation_kill_arbiter.sv
// Directed bench for violation_kill_arbiter: two instances (8-bit and 2-bit
// kill counters) share stimulus; a timeline model is compared every cycle.
module tb_violation_kill_arbiter;
    localparam int unsigned N     = 4;
    localparam int unsigned HOLD  = 8;
    localparam logic [15:0] HNDLR = 16'hFFFE;

    logic         clk = 1'b0;
    logic         reset;
    logic [15:0]  pc;
    logic [N-1:0] viol_req;
    logic [N-1:0] viol_mask;
    logic         cause_clr;

    int checks = 0;
    int errors = 0;

    violation_kill_arbiter_if #(.N_SRC(N), .CNT_W(8)) bus_a ();
    violation_kill_arbiter_if #(.N_SRC(N), .CNT_W(2)) bus_b ();

    assign bus_a.pc = pc;  assign bus_a.viol_req = viol_req;
    assign bus_a.viol_mask = viol_mask;  assign bus_a.cause_clr = cause_clr;
    assign bus_b.pc = pc;  assign bus_b.viol_req = viol_req;
    assign bus_b.viol_mask = viol_mask;  assign bus_b.cause_clr = cause_clr;

    violation_kill_arbiter #(.N_SRC(N), .RESET_HANDLER(HNDLR), .HOLD_CYCLES(HOLD), .CNT_W(8))
        dut_a (.clk(clk), .reset(reset), .bus(bus_a.slave));
    violation_kill_arbiter #(.N_SRC(N), .RESET_HANDLER(HNDLR), .HOLD_CYCLES(HOLD), .CNT_W(2))
        dut_b (.clk(clk), .reset(reset), .bus(bus_b.slave));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Timeline model: a kill accepted at edge k may release no earlier than
    // edge k+HOLD+1, and only when pc is at the handler with no masked request.
    bit           m_busy = 1'b0;
    int           m_kill_edge = 0;
    int           m_edge = 0;
    int           m_count = 0;
    logic [N-1:0] m_cause = '0;
    logic         m_valid = 1'b0;
    logic [N-1:0] m_ack = '0;

    initial begin
        logic [N-1:0] e;
        logic [N-1:0] w;
        forever begin
            @(posedge clk);
            m_edge++;
            e = viol_req & viol_mask;
            w = '0;
            for (int i = N - 1; i >= 0; i--) if (e[i]) w = N'(1) << i;
            m_ack = '0;
            if (reset) begin
                m_busy = 1'b0; m_count = 0; m_cause = '0; m_valid = 1'b0;
            end else if (!m_busy) begin
                if (e != '0) begin
                    m_busy = 1'b1; m_kill_edge = m_edge;
                    m_cause = w; m_valid = 1'b1; m_ack = w; m_count++;
                end else if (cause_clr) begin
                    m_cause = '0; m_valid = 1'b0;
                end
            end else if (m_edge >= m_kill_edge + int'(HOLD) + 1 && pc == HNDLR && e == '0) begin
                m_busy = 1'b0;
            end
            #1;
            chk("sys_reset_a", 32'(bus_a.sys_reset), 32'(m_busy));
            chk("viol_ack_a", 32'(bus_a.viol_ack), 32'(m_ack));
            chk("cause_a", 32'(bus_a.cause), 32'(m_cause));
            chk("cause_valid_a", 32'(bus_a.cause_valid), 32'(m_valid));
            chk("kill_count_a", 32'(bus_a.kill_count), 32'((m_count > 255) ? 255 : m_count));
            chk("sys_reset_b", 32'(bus_b.sys_reset), 32'(m_busy));
            chk("viol_ack_b", 32'(bus_b.viol_ack), 32'(m_ack));
            chk("kill_count_b", 32'(bus_b.kill_count), 32'((m_count > 3) ? 3 : m_count));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_armed();
        int k;
        k = 0;
        while (bus_a.sys_reset !== 1'b0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (bus_a.sys_reset !== 1'b0) begin
            errors++;
            $display("FAIL wait_armed: sys_reset still %b after %0d cycles", bus_a.sys_reset, k);
        end
    endtask

    // One-cycle request pulse; returns in the cycle after the accepting edge
    task automatic kill(input logic [N-1:0] req);
        viol_req = req;
        cyc(1);
        viol_req = '0;
    endtask

    initial begin
        reset = 1'b1; pc = HNDLR; viol_req = '0; viol_mask = 4'hF; cause_clr = 1'b0;
        cyc(2);
        chk("rst_sys_reset", 32'(bus_a.sys_reset), 32'd0);
        chk("rst_kill_count", 32'(bus_a.kill_count), 32'd0);
        chk("rst_cause", 32'(bus_a.cause), 32'd0);
        reset = 1'b0;
        cyc(1);

        // Single kill: high t+1..t+9, low at t+10
        kill(4'b0100);
        chk("single_ack", 32'(bus_a.viol_ack), 32'h4);
        chk("single_cause", 32'(bus_a.cause), 32'h4);
        chk("single_count", 32'(bus_a.kill_count), 32'd1);
        cyc(8);
        chk("single_t9_reset", 32'(bus_a.sys_reset), 32'd1);
        cyc(1);
        chk("single_t10_reset", 32'(bus_a.sys_reset), 32'd0);

        // Priority and masking
        kill(4'b1010);
        chk("prio_cause", 32'(bus_a.cause), 32'h2);
        wait_armed();
        viol_mask = 4'b1101;
        kill(4'b1010);
        chk("mask_cause", 32'(bus_a.cause), 32'h8);
        wait_armed();
        kill(4'b0010);
        chk("masked_no_kill", 32'(bus_a.sys_reset), 32'd0);
        chk("masked_count", 32'(bus_a.kill_count), 32'd3);
        viol_mask = 4'hF;

        // Handler gating with request held high
        pc = 16'h1234;
        viol_req = 4'b0001;
        cyc(HOLD + 1 + 50);
        chk("gate_pc_off", 32'(bus_a.sys_reset), 32'd1);
        pc = HNDLR;
        cyc(5);
        chk("gate_req_high", 32'(bus_a.sys_reset), 32'd1);
        viol_req = '0;
        cyc(1);
        chk("gate_release", 32'(bus_a.sys_reset), 32'd0);
        chk("gate_count", 32'(bus_a.kill_count), 32'd4);

        // Cause clear ignored in WAIT_HANDLER, honoured in ARMED, loses to a kill
        pc = 16'h1234;
        kill(4'b0001);
        cyc(HOLD + 1);
        cause_clr = 1'b1;
        cyc(1);
        cause_clr = 1'b0;
        chk("clr_wait_cause", 32'(bus_a.cause), 32'h1);
        chk("clr_wait_valid", 32'(bus_a.cause_valid), 32'd1);
        pc = HNDLR;
        wait_armed();
        cause_clr = 1'b1;
        cyc(1);
        chk("clr_armed_cause", 32'(bus_a.cause), 32'h0);
        chk("clr_armed_valid", 32'(bus_a.cause_valid), 32'd0);
        kill(4'b0001);
        cause_clr = 1'b0;
        chk("clr_vs_kill_cause", 32'(bus_a.cause), 32'h1);
        chk("clr_vs_kill_valid", 32'(bus_a.cause_valid), 32'd1);
        wait_armed();

        // Saturation on the 2-bit counter: 1,2,3,3,3
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            kill(4'b1000);
            chk("sat_count_b", 32'(bus_b.kill_count), 32'((i > 3) ? 3 : i));
            chk("sat_count_a", 32'(bus_a.kill_count), 32'(i));
            wait_armed();
        end

        // Reset mid-HOLD, then a fresh kill counts from 1
        kill(4'b0100);
        cyc(2);
        reset = 1'b1;
        cyc(1);
        chk("midhold_reset", 32'(bus_a.sys_reset), 32'd0);
        chk("midhold_cause", 32'(bus_a.cause), 32'h0);
        chk("midhold_count", 32'(bus_a.kill_count), 32'd0);
        reset = 1'b0;
        kill(4'b0010);
        chk("after_rst_count", 32'(bus_a.kill_count), 32'd1);
        chk("after_rst_ack", 32'(bus_a.viol_ack), 32'h2);
        wait_armed();
        cyc(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
